// File: rtl/multicycle_control.sv
// Multicycle RISC-V main control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout and illegal-opcode trap.
// Optional retired-instruction counter enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             jump,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluop,
  output logic [1:0]       memtoreg,
  output logic             regwrite,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Counter only needs to reach MEM_TIMEOUT-1 before the trap fires
  localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          state_q, state_d;
  logic [6:0]      opc_q;
  logic [TO_W-1:0] to_cnt;
  logic            trap_q;
  logic [1:0]      cause_q;
  logic [1:0]      new_cause;
  logic            timeout_c;

  assign timeout_c = (to_cnt == TO_W'(MEM_TIMEOUT - 1)) && !mem_ready;

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    new_cause = 2'b00;
    mem_req   = 1'b0;
    iord      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alusrc_a  = 1'b0;
    alusrc_b  = 2'b00;
    aluop     = 2'b00;
    memtoreg  = 2'b00;
    regwrite  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        memread  = 1'b1;
        alusrc_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_c) begin
          state_d   = S_TRAP;
          new_cause = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_IALU, OP_STORE, OP_BRANCH,
          OP_JALR, OP_JAL, OP_RTYPE: state_d = S_EXEC;
          default: begin
            state_d   = S_TRAP;
            new_cause = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opc_q)
          OP_RTYPE: begin
            alusrc_a = 1'b1;
            aluop    = 2'b10;
            state_d  = S_WB;
          end
          OP_IALU: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'b10;
            aluop    = 2'b11;
            state_d  = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'b10;
            state_d  = S_MEM;
          end
          OP_BRANCH: begin
            alusrc_a = 1'b1;
            aluop    = 2'b01;
            branch   = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            alusrc_a = (opc_q == OP_JALR);
            alusrc_b = 2'b10;
            jump     = 1'b1;
            pc_write = 1'b1;
            regwrite = 1'b1;
            memtoreg = 2'b10;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        memread  = (opc_q == OP_LOAD);
        memwrite = (opc_q == OP_STORE);
        if (mem_ready) begin
          state_d = (opc_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout_c) begin
          state_d   = S_TRAP;
          new_cause = CAUSE_TIMEOUT;
        end
      end

      S_WB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
        case (opc_q)
          OP_RTYPE: begin
            alusrc_a = 1'b1;
            aluop    = 2'b10;
          end
          OP_IALU: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'b10;
            aluop    = 2'b11;
          end
          OP_LOAD: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'b10;
            memtoreg = 2'b01;
          end
          default: ;
        endcase
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase

    // Reset abandons the instruction: no strobes may escape while it is held
    if (reset) begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      alusrc_a = 1'b0;
      alusrc_b = 2'b00;
      aluop    = 2'b00;
      memtoreg = 2'b00;
      regwrite = 1'b0;
    end
  end

  // State, latched opcode, stall counter and sticky trap
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= 7'd0;
      to_cnt  <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opc_q <= opcode;
      if ((state_d != state_q) || mem_ready) begin
        to_cnt <= '0;
      end else if (mem_req) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (new_cause != 2'b00) begin
        trap_q  <= 1'b1;
        cause_q <= new_cause;
      end
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic             retire_c;
  logic [CNT_W-1:0] instret_q;

  assign retire_c = ((state_q == S_EXEC) &&
                     ((opc_q == OP_BRANCH) || (opc_q == OP_JAL) || (opc_q == OP_JALR))) ||
                    ((state_q == S_MEM) && (opc_q == OP_STORE) && mem_ready) ||
                    (state_q == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire_c) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret_count = instret_q;
`else
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus trap, timeout and retire-count sequences.
module tb_multicycle_control;

  localparam int unsigned CNT_W = 4;
`ifdef MULTICYCLE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             mem_req, iord, memread, memwrite, ir_write, pc_write;
  logic             branch, jump, alusrc_a, regwrite, trap;
  logic [1:0]       alusrc_b, aluop, memtoreg, trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret_count;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memread(memread), .memwrite(memwrite),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .jump(jump),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .memtoreg(memtoreg),
    .regwrite(regwrite), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  logic [15:0] act_ctrl;
  assign act_ctrl = {mem_req, iord, memread, memwrite, ir_write, pc_write, branch, jump,
                     alusrc_a, alusrc_b, aluop, memtoreg, regwrite};

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       rdy;
    logic [2:0] st;
    logic [15:0] ctrl;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] C_NONE, C_FETCH_W, C_FETCH_R, C_EX_R, C_WB_R, C_EX_I, C_WB_I, C_EX_LS;
  logic [15:0] C_MEM_LD, C_MEM_ST, C_WB_LD, C_EX_BR, C_EX_JAL, C_EX_JALR;

  function automatic logic [15:0] mk(input logic mreq, input logic io, input logic mrd,
                                     input logic mwr, input logic irw, input logic pcw,
                                     input logic br, input logic jmp, input logic a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] m2r, input logic rw);
    return {mreq, io, mrd, mwr, irw, pcw, br, jmp, a, b, op, m2r, rw};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [15:0] ctrl,
                           input logic trp, input logic [1:0] cause);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctrl"}, 32'(act_ctrl), 32'(ctrl));
    chk({tag, ".trap"}, 32'(trap), 32'(trp));
    chk({tag, ".cause"}, 32'(trap_cause), 32'(cause));
  endtask

  // Inputs change 1 time unit after the rising edge; checks run mid-cycle
  task automatic drive(input logic r, input logic [6:0] o, input logic m);
    reset = r; opcode = o; mem_ready = m;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 7'd0, 1'b0);
    tick();
  endtask

  task automatic add(input logic r, input logic [6:0] o, input logic m,
                     input logic [2:0] s, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.opc = o; v.rdy = m; v.st = s; v.ctrl = c;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] exp_cnt(input int k);
    return PERF ? 32'(k % 16) : 32'd0;
  endfunction

  initial begin
    C_NONE    = 16'd0;
    C_FETCH_W = mk(1,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    C_FETCH_R = mk(1,0,1,0,1,1,0,0,0,2'b01,2'b00,2'b00,0);
    C_EX_R    = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    C_WB_R    = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,1);
    C_EX_I    = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0);
    C_WB_I    = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,1);
    C_EX_LS   = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    C_MEM_LD  = mk(1,1,1,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    C_MEM_ST  = mk(1,1,0,1,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    C_WB_LD   = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b01,1);
    C_EX_BR   = mk(0,0,0,0,0,0,1,0,1,2'b00,2'b01,2'b00,0);
    C_EX_JAL  = mk(0,0,0,0,0,1,0,1,0,2'b10,2'b00,2'b10,1);
    C_EX_JALR = mk(0,0,0,0,0,1,0,1,1,2'b10,2'b00,2'b10,1);

    // Reset held with mem_ready high: outputs must stay gated
    add(1, 7'd0,     1, 3'd0, C_NONE);
    // R-type, memory ready immediately
    add(0, OP_BAD,   1, 3'd0, C_FETCH_R);
    add(0, OP_RTYPE, 1, 3'd1, C_NONE);
    add(0, OP_BAD,   0, 3'd2, C_EX_R);
    add(0, OP_BAD,   0, 3'd4, C_WB_R);
    // Load with 3 FETCH stalls and 2 MEM stalls
    add(0, 7'd0,     0, 3'd0, C_FETCH_W);
    add(0, 7'd0,     0, 3'd0, C_FETCH_W);
    add(0, 7'd0,     0, 3'd0, C_FETCH_W);
    add(0, 7'd0,     1, 3'd0, C_FETCH_R);
    add(0, OP_LOAD,  0, 3'd1, C_NONE);
    add(0, OP_BAD,   0, 3'd2, C_EX_LS);
    add(0, OP_BAD,   0, 3'd3, C_MEM_LD);
    add(0, OP_BAD,   0, 3'd3, C_MEM_LD);
    add(0, OP_BAD,   1, 3'd3, C_MEM_LD);
    add(0, OP_BAD,   0, 3'd4, C_WB_LD);
    // Store then branch
    add(0, 7'd0,     1, 3'd0, C_FETCH_R);
    add(0, OP_STORE, 0, 3'd1, C_NONE);
    add(0, 7'd0,     0, 3'd2, C_EX_LS);
    add(0, 7'd0,     1, 3'd3, C_MEM_ST);
    add(0, 7'd0,     1, 3'd0, C_FETCH_R);
    add(0, OP_BRANCH,1, 3'd1, C_NONE);
    add(0, 7'd0,     1, 3'd2, C_EX_BR);
    // I-ALU then jalr
    add(0, 7'd0,     1, 3'd0, C_FETCH_R);
    add(0, OP_IALU,  0, 3'd1, C_NONE);
    add(0, 7'd0,     0, 3'd2, C_EX_I);
    add(0, 7'd0,     0, 3'd4, C_WB_I);
    add(0, 7'd0,     1, 3'd0, C_FETCH_R);
    add(0, OP_JALR,  0, 3'd1, C_NONE);
    add(0, 7'd0,     0, 3'd2, C_EX_JALR);
    add(0, 7'd0,     0, 3'd0, C_FETCH_W);

    reset = 1'b1; opcode = 7'd0; mem_ready = 1'b0;
    @(posedge clk);
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].opc, tbl[i].rdy);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].ctrl, 1'b0, 2'b00);
      tick();
    end
    // Six instructions retired in the table
    drive(1'b0, 7'd0, 1'b0);
    chk("table_instret", 32'(instret_count), exp_cnt(6));

    // Illegal opcode trap, held 20 cycles, cleared by reset
    do_reset();
    drive(1'b0, OP_BAD, 1'b1); check_all("ill_fetch", 3'd0, C_FETCH_R, 1'b0, 2'b00); tick();
    drive(1'b0, OP_BAD, 1'b0); check_all("ill_decode", 3'd1, C_NONE, 1'b0, 2'b00); tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, OP_BAD, 1'(i % 2));
      check_all($sformatf("ill_trap%0d", i), 3'd5, C_NONE, 1'b1, 2'b01);
      tick();
    end
    do_reset();
    drive(1'b0, 7'd0, 1'b0); check_all("ill_after_reset", 3'd0, C_FETCH_W, 1'b0, 2'b00); tick();

    // FETCH timeout after exactly 4 stalled cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 7'd0, 1'b0);
      check_all($sformatf("to_fetch%0d", i), 3'd0, C_FETCH_W, 1'b0, 2'b00);
      tick();
    end
    drive(1'b0, 7'd0, 1'b1); check_all("to_trap", 3'd5, C_NONE, 1'b1, 2'b10); tick();

    // Ready on the 4th cycle wins over the timeout
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'd0, 1'b0); tick();
    end
    drive(1'b0, 7'd0, 1'b1); check_all("to_edge_fetch", 3'd0, C_FETCH_R, 1'b0, 2'b00); tick();
    drive(1'b0, OP_RTYPE, 1'b0); check_all("to_edge_decode", 3'd1, C_NONE, 1'b0, 2'b00); tick();

    // MEM timeout on a load
    do_reset();
    drive(1'b0, 7'd0, 1'b1); tick();
    drive(1'b0, OP_LOAD, 1'b0); tick();
    drive(1'b0, 7'd0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 7'd0, 1'b0);
      check_all($sformatf("to_mem%0d", i), 3'd3, C_MEM_LD, 1'b0, 2'b00);
      tick();
    end
    drive(1'b0, 7'd0, 1'b0); check_all("to_mem_trap", 3'd5, C_NONE, 1'b1, 2'b10); tick();

    // 17 jal instructions: counter wraps at 16
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, 7'd0, 1'b1);
      chk($sformatf("jal_cnt%0d", k), 32'(instret_count), exp_cnt(k));
      tick();
      drive(1'b0, OP_JAL, 1'b0); tick();
      drive(1'b0, 7'd0, 1'b0);
      check_all($sformatf("jal_exec%0d", k), 3'd2, C_EX_JAL, 1'b0, 2'b00);
      tick();
    end
    drive(1'b0, 7'd0, 1'b0);
    chk("jal_cnt_final", 32'(instret_count), exp_cnt(17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
